// File: rtl/matmult_sequencer.sv
// rtl/matmult_sequencer.sv - sequences a streamed 2x2 operand pair into a multiplier and streams the 2x2 result back out
module matmult_sequencer #(
    parameter int WIDTH       = 32,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a11,
    output logic [WIDTH-1:0] a12,
    output logic [WIDTH-1:0] a21,
    output logic [WIDTH-1:0] a22,
    output logic [WIDTH-1:0] b11,
    output logic [WIDTH-1:0] b12,
    output logic [WIDTH-1:0] b21,
    output logic [WIDTH-1:0] b22,
    input  logic [WIDTH-1:0] c11,
    input  logic [WIDTH-1:0] c12,
    input  logic [WIDTH-1:0] c21,
    input  logic [WIDTH-1:0] c22,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {LOAD, HOLD, DRAIN} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t           state;
    logic [WIDTH-1:0] operand [8];
    logic [WIDTH-1:0] result  [4];
    logic [2:0]       load_idx;
    logic [7:0]       hold_cnt;
    logic [1:0]       drain_idx;
    logic [1:0]       next_drain;

    assign next_drain = drain_idx + 2'd1;

    assign a11 = operand[0];
    assign a12 = operand[1];
    assign a21 = operand[2];
    assign a22 = operand[3];
    assign b11 = operand[4];
    assign b12 = operand[5];
    assign b21 = operand[6];
    assign b22 = operand[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            load_idx  <= 3'd0;
            hold_cnt  <= 8'd0;
            drain_idx <= 2'd0;
            for (int i = 0; i < 8; i++) operand[i] <= '0;
            for (int i = 0; i < 4; i++) result[i] <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        operand[load_idx] <= in_data;
                        load_idx          <= load_idx + 3'd1;
                        if (load_idx == 3'd7) begin
                            state    <= HOLD;
                            hold_cnt <= 8'd0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (hold_cnt == HOLD_LAST) begin
                        result[0] <= c11;
                        result[1] <= c12;
                        result[2] <= c21;
                        result[3] <= c22;
                        drain_idx <= 2'd0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle moves result[0] into the output register before presenting it.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= result[0];
                        drain_idx <= 2'd0;
                    end else if (out_ready) begin
                        if (drain_idx == 2'd3) begin
                            drain_idx <= 2'd0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= LOAD;
                        end else begin
                            drain_idx <= next_drain;
                            out_data  <= result[next_drain];
                        end
                    end
                end
                default: begin
                    state     <= LOAD;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmult_sequencer.sv
// tb/tb_matmult_sequencer.sv - scoreboard bench for matmult_sequencer with HOLD_CYCLES of 4 and 1
module tb_matmult_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     [2];
    logic [31:0] in_data   [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] ops       [2][8];
    logic [31:0] c         [2][4];
    logic [31:0] out_data  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        busy      [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int H = (g == 0) ? 4 : 1;

        logic [31:0] exp_q [$];
        logic [31:0] words [$];
        logic [31:0] loaded [8];
        logic [31:0] prod [4];
        int          k = -1;
        bit          start = 0;
        bit          rst_seen = 0;
        bit          prev_stall = 0;
        logic [31:0] prev_data = '0;
        logic        exp_busy;

        matmult_sequencer #(.WIDTH(32), .HOLD_CYCLES(H)) dut (
            .clk(clk), .reset(reset[g]),
            .in_data(in_data[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .a11(ops[g][0]), .a12(ops[g][1]), .a21(ops[g][2]), .a22(ops[g][3]),
            .b11(ops[g][4]), .b12(ops[g][5]), .b21(ops[g][6]), .b22(ops[g][7]),
            .c11(c[g][0]), .c12(c[g][1]), .c21(c[g][2]), .c22(c[g][3]),
            .out_data(out_data[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .busy(busy[g])
        );

        always @(negedge clk) begin
            if (reset[g]) begin
                if (rst_seen) begin
                    check($sformatf("u%0d_reset_flags", g),
                          {29'd0, in_ready[g], out_valid[g], busy[g]}, 32'h4);
                    check($sformatf("u%0d_reset_out_data", g), out_data[g], 32'h0);
                    check($sformatf("u%0d_reset_ops", g),
                          ops[g][0] | ops[g][1] | ops[g][2] | ops[g][3] |
                          ops[g][4] | ops[g][5] | ops[g][6] | ops[g][7], 32'h0);
                end
                rst_seen   = 1;
                k          = -1;
                start      = 0;
                prev_stall = 0;
                exp_q.delete();
                words.delete();
            end else begin
                rst_seen = 0;
                if (start) begin
                    k     = 0;
                    start = 0;
                end else if (k >= 0) begin
                    k++;
                end
                // Block is busy from the edge after the 8th accept until the last result handshake.
                exp_busy = (k >= 0) || (exp_q.size() != 0);
                check($sformatf("u%0d_busy", g), {31'd0, busy[g]}, {31'd0, exp_busy});
                check($sformatf("u%0d_in_ready", g), {31'd0, in_ready[g]}, {31'd0, !exp_busy});
                if (k >= 0 && k <= H)
                    check($sformatf("u%0d_early_valid_k%0d", g, k), {31'd0, out_valid[g]}, 32'h0);
                if (k == 0 || k == H + 1)
                    for (int i = 0; i < 8; i++)
                        check($sformatf("u%0d_operand%0d", g, i), ops[g][i], loaded[i]);
                if (k == H + 1) begin
                    check($sformatf("u%0d_valid_rise", g), {31'd0, out_valid[g]}, 32'h1);
                    k = -1;
                end
                if (out_valid[g]) begin
                    if (prev_stall)
                        check($sformatf("u%0d_stall_hold", g), out_data[g], prev_data);
                    if (out_ready[g]) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL u%0d_unexpected_out: got %0h expected no output", g, out_data[g]);
                        end else begin
                            check($sformatf("u%0d_out_data", g), out_data[g], exp_q.pop_front());
                        end
                    end
                end else if (prev_stall) begin
                    check($sformatf("u%0d_valid_dropped", g), 32'h0, 32'h1);
                end
                prev_stall = out_valid[g] && !out_ready[g];
                prev_data  = out_data[g];
                if (in_valid[g] && in_ready[g]) begin
                    words.push_back(in_data[g]);
                    if (words.size() == 8) begin
                        for (int i = 0; i < 8; i++) loaded[i] = words[i];
                        prod[0] = loaded[0] * loaded[4] + loaded[1] * loaded[6];
                        prod[1] = loaded[0] * loaded[5] + loaded[1] * loaded[7];
                        prod[2] = loaded[2] * loaded[4] + loaded[3] * loaded[6];
                        prod[3] = loaded[2] * loaded[5] + loaded[3] * loaded[7];
                        for (int i = 0; i < 4; i++) exp_q.push_back(prod[i]);
                        words.delete();
                        start = 1;
                    end
                end
            end
            // The multiplier's result is only correct during the single cycle the block must sample it.
            for (int i = 0; i < 4; i++)
                c[g][i] = (!reset[g] && k == H - 1) ? prod[i] : $urandom;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        reset[d]    = 1'b1;
        in_valid[d] = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        reset[d] = 1'b0;
    endtask

    task automatic load_words(input int d, input logic [31:0] w[8], input int gap_mode, input int stop_after);
        int  i      = 0;
        int  budget = 0;
        bit  phase  = 1;
        bit  v;
        while (i < stop_after && budget < 200) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       begin v = phase; phase = !phase; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid[d] = v;
            in_data[d]  = v ? w[i] : $urandom;
            @(negedge clk);
            if (in_valid[d] && in_ready[d]) i++;
            cyc();
            budget++;
        end
        in_valid[d] = 1'b0;
        if (budget >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL u%0d_load_timeout: got %0d accepts expected %0d", d, i, stop_after);
        end
    endtask

    task automatic finish_txn(input int d, input int bp_mode, input bit junk);
        int budget = 0;
        int hs     = 0;
        int stall  = 0;
        while (!in_ready[d] && budget < 300) begin
            case (bp_mode)
                0:       out_ready[d] = 1'b1;
                1:       out_ready[d] = ($urandom_range(0, 2) != 0);
                default: begin
                    out_ready[d] = !(hs == 1 && stall < 3 && out_valid[d]);
                    if (!out_ready[d]) stall++;
                end
            endcase
            if (junk) begin
                in_valid[d] = 1'b1;
                in_data[d]  = 32'hDEAD;
            end
            @(negedge clk);
            if (out_valid[d] && out_ready[d]) hs++;
            cyc();
            budget++;
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        if (budget >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL u%0d_drain_timeout: got %0d handshakes expected 4", d, hs);
        end
        cyc();
    endtask

    logic [31:0] seq1  [8];
    logic [31:0] seq9  [8];
    logic [31:0] rnd   [8];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            seq1[i] = 32'(i + 1);
            seq9[i] = 32'(i + 9);
        end
        for (int i = 0; i < 3; i++) cyc();
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        cyc();

        for (int d = 0; d < 2; d++) begin
            do_reset(d);
            load_words(d, seq1, 0, 8);
            finish_txn(d, 0, 0);
            load_words(d, seq1, 1, 8);
            finish_txn(d, 2, 0);
            load_words(d, seq1, 0, 8);
            finish_txn(d, 0, 1);
            load_words(d, seq1, 0, 3);
            do_reset(d);
            load_words(d, seq9, 2, 8);
            finish_txn(d, 1, 0);
            load_words(d, seq1, 0, 8);
            cyc();
            do_reset(d);
            for (int t = 0; t < 8; t++) begin
                for (int i = 0; i < 8; i++) rnd[i] = $urandom;
                load_words(d, rnd, 2, 8);
                finish_txn(d, t % 3, t[0]);
            end
        end
        for (int i = 0; i < 4; i++) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
